mem_dma_arbiter: RTL and testbench
==================================

Name: mem_dma_arbiter

Overview:
- Shares the memory block's second read port and its write port between the CPU data port and a built-in DMA engine.
- The DMA engine does block copy (memory to memory) and block fill (constant to memory) over the full 16-bit address space. Typical uses are frame-buffer clears and tile-map uploads.
- The CPU always wins a port; the DMA uses idle cycles only, so CPU timing is unchanged.
- Sits between the CPU and the memory block's raddr1/ren/wen/waddr/wdata inputs.

Parameters:
- RD_LAT, 2, memory read latency in cycles from address presented to rdata1 valid.
- BUF_DEPTH, 3, read-data skid buffer entries; must be >= RD_LAT+1.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- cpu_ren  in  1  CPU read request
- cpu_raddr  in  16  CPU read address
- cpu_wen  in  1  CPU write request
- cpu_waddr  in  16  CPU write address
- cpu_wdata  in  16  CPU write data
- dma_start  in  1  one-cycle start pulse
- dma_mode  in  1  0 = copy, 1 = fill
- dma_src  in  16  copy source base
- dma_dst  in  16  destination base
- dma_len  in  16  word count
- dma_fill  in  16  fill value
- dma_busy  out  1  engine active
- dma_done  out  1  one-cycle completion pulse
- mem_raddr  out  16  to memory raddr1
- mem_ren  out  1  to memory ren
- mem_wen  out  1  to memory wen
- mem_waddr  out  16  to memory waddr
- mem_wdata  out  16  to memory wdata
- mem_rdata  in  16  from memory rdata1 (the CPU also receives rdata1 directly)

Behaviour:
- Reset values: dma_busy=0, dma_done=0, state IDLE, skid buffer empty, in-flight tags cleared. Reset mid-transfer aborts it with no done pulse.
- Port muxing is combinational, with zero added CPU latency.
- mem_raddr = cpu_raddr when cpu_ren, else the DMA read address.
- mem_ren = cpu_ren only. DMA reads never assert ren, so a DMA read of 0xFFFF does not pop PS/2 data.
- mem_wen = cpu_wen | dma_wr_go. mem_waddr/mem_wdata select the CPU values when cpu_wen, else the DMA values.
- A DMA read issues only if !cpu_ren. A DMA write issues only if !cpu_wen.
- States:
  - IDLE: dma_start latches mode/src/dst/len/fill into internal registers.
    - len=0 -> DONE directly, with no memory accesses.
    - otherwise -> RUN; dma_busy=1 from the next cycle.
  - RUN, copy mode:
    - Issue a read at src+rd_idx when the read port is free, rd_idx < len, and (in-flight + buffered) < BUF_DEPTH.
    - A RD_LAT-deep tag shift register marks DMA read slots. When a tag emerges, mem_rdata is pushed into the skid buffer.
    - When the write port is free and the buffer is non-empty: pop, write to dst+wr_idx, increment wr_idx.
  - RUN, fill mode: no reads. Write dma_fill to dst+wr_idx on every free write-port cycle.
  - RUN -> DONE when wr_idx == len after the final write.
  - DONE: dma_done=1 for one cycle, dma_busy=0 -> IDLE.
- Address arithmetic is 16-bit and wraps (0xFFFF+1 = 0x0000). rd_idx/wr_idx are 16-bit; len up to 0xFFFF.
- A dma_start while busy or in DONE is ignored, and the latched config is unchanged.
- A buffer overflow is impossible by the issue rule. An assertion checks that no push occurs when the buffer is full.
- Overlapping copy regions are copied in ascending order; forward overlap with dst > src is undefined.
- Simultaneous events:
  - A buffer push and pop in the same cycle are both honoured; the count is unchanged.
  - CPU write in the same cycle as a DMA pop request: the CPU wins and the entry stays buffered.
- Throughput with an idle CPU:
  - Copy: one word per cycle after an initial RD_LAT-cycle fill.
  - Fill: one word per cycle.

Test Plan:
- Fill, idle CPU: dst=0xE000, len=4, fill=0x1234 -> writes to E000..E003 on 4 consecutive cycles starting the cycle after start; done pulse; busy was high 5 cycles.
- Copy, idle CPU: RAM[0x0100..0x0107]=1..8, src=0x0100, dst=0xC000, len=8 -> tile map C000..C007=1..8; first write RD_LAT+1 cycles after start; mem_ren never asserted.
- Copy with CPU contention: same copy while CPU writes every other cycle and reads continuously for 10 cycles -> CPU accesses are never delayed or altered; final data is correct; no buffer overflow assertion fires.
- Wrap and PS/2 safety: copy src=0xFFFE, len=3, dst=0x0200 -> reads 0xFFFE, 0xFFFF, 0x0000; ps2_ren stays 0; dst 0x0200..0x0202 receive the returned data.
- Edge starts: len=0 -> done the next cycle with no writes. Start during RUN -> ignored, original transfer completes. rst asserted mid-copy -> busy=0 immediately, no done pulse, no further DMA writes.

Source files
------------

// File: rtl/mem_dma_arbiter_if.sv
// Bus bundle between the CPU data port, the DMA control block and the memory's
// second read port plus write port. The arbiter uses "master"; its environment uses "slave".
interface mem_dma_arbiter_if;
  logic        cpu_ren;
  logic [15:0] cpu_raddr;
  logic        cpu_wen;
  logic [15:0] cpu_waddr;
  logic [15:0] cpu_wdata;
  logic        dma_start;
  logic        dma_mode;
  logic [15:0] dma_src;
  logic [15:0] dma_dst;
  logic [15:0] dma_len;
  logic [15:0] dma_fill;
  logic        dma_busy;
  logic        dma_done;
  logic [15:0] mem_raddr;
  logic        mem_ren;
  logic        mem_wen;
  logic [15:0] mem_waddr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic [1:0]  dbg_state;

  modport master (
    input  cpu_ren, cpu_raddr, cpu_wen, cpu_waddr, cpu_wdata,
    input  dma_start, dma_mode, dma_src, dma_dst, dma_len, dma_fill,
    input  mem_rdata,
    output dma_busy, dma_done, dbg_state,
    output mem_raddr, mem_ren, mem_wen, mem_waddr, mem_wdata
  );

  modport slave (
    output cpu_ren, cpu_raddr, cpu_wen, cpu_waddr, cpu_wdata,
    output dma_start, dma_mode, dma_src, dma_dst, dma_len, dma_fill,
    output mem_rdata,
    input  dma_busy, dma_done, dbg_state,
    input  mem_raddr, mem_ren, mem_wen, mem_waddr, mem_wdata
  );
endinterface

// File: rtl/mem_dma_arbiter.sv
// CPU/DMA port arbiter with a copy/fill DMA engine that only uses cycles the CPU
// leaves idle on the memory read port and write port. BUF_DEPTH must be >= RD_LAT+1.
module mem_dma_arbiter #(
  parameter int RD_LAT    = 2,
  parameter int BUF_DEPTH = 3
) (
  input logic               clk,
  input logic               rst,
  mem_dma_arbiter_if.master bus
);

  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              mode_q, mode_d;
  logic [15:0]       src_q, src_d;
  logic [15:0]       dst_q, dst_d;
  logic [15:0]       len_q, len_d;
  logic [15:0]       fill_q, fill_d;
  logic [15:0]       rd_idx_q, rd_idx_d;
  logic [15:0]       wr_idx_q, wr_idx_d;
  logic [RD_LAT-1:0] tag_q, tag_d;
  logic [15:0]       buf_q [BUF_DEPTH];
  logic [15:0]       buf_d [BUF_DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [CNT_W-1:0]  inflight;
  logic              room;
  logic              push;
  logic              pop;
  logic              store;
  logic              take;
  logic              head_avail;
  logic [15:0]       head_data;
  logic              dma_rd_go;
  logic              dma_wr_go;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) inflight = inflight + CNT_W'(tag_q[i]);
  end

  // Reads already in flight count against the buffer so every returned word has a slot.
  assign room       = ({1'b0, inflight} + {1'b0, cnt_q}) < (CNT_W + 1)'(BUF_DEPTH);
  assign push       = tag_q[RD_LAT-1];
  assign head_avail = (cnt_q != '0) || push;
  assign head_data  = (cnt_q != '0) ? buf_q[rd_ptr_q] : bus.mem_rdata;

  assign dma_rd_go = (state_q == RUN) && !mode_q && !bus.cpu_ren && (rd_idx_q != len_q) && room;
  assign dma_wr_go = (state_q == RUN) && !bus.cpu_wen && (wr_idx_q != len_q) && (mode_q || head_avail);
  assign pop       = dma_wr_go && !mode_q;
  // An empty buffer with a word arriving and a pop in the same cycle forwards it straight through.
  assign store     = push && !(pop && (cnt_q == '0));
  assign take      = pop && (cnt_q != '0);

  assign bus.mem_raddr = bus.cpu_ren ? bus.cpu_raddr : src_q + rd_idx_q;
  assign bus.mem_ren   = bus.cpu_ren;
  assign bus.mem_wen   = bus.cpu_wen | dma_wr_go;
  assign bus.mem_waddr = bus.cpu_wen ? bus.cpu_waddr : dst_q + wr_idx_q;
  assign bus.mem_wdata = bus.cpu_wen ? bus.cpu_wdata : (mode_q ? fill_q : head_data);
  assign bus.dma_busy  = busy_q;
  assign bus.dma_done  = done_q;
  assign bus.dbg_state = state_q;

  // dma_start is a single-cycle request honoured only in IDLE; dma_done is a
  // single-cycle completion pulse; dma_busy spans the RUN state only.
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    src_d    = src_q;
    dst_d    = dst_q;
    len_d    = len_q;
    fill_d   = fill_q;
    rd_idx_d = rd_idx_q;
    wr_idx_d = wr_idx_q;
    buf_d    = buf_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q + CNT_W'(store) - CNT_W'(take);
    tag_d[0] = dma_rd_go;
    for (int i = 1; i < RD_LAT; i++) tag_d[i] = tag_q[i-1];

    if (store) begin
      buf_d[wr_ptr_q] = bus.mem_rdata;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (take) rd_ptr_d = ptr_inc(rd_ptr_q);

    case (state_q)
      IDLE: begin
        if (bus.dma_start) begin
          mode_d   = bus.dma_mode;
          src_d    = bus.dma_src;
          dst_d    = bus.dma_dst;
          len_d    = bus.dma_len;
          fill_d   = bus.dma_fill;
          rd_idx_d = '0;
          wr_idx_d = '0;
          state_d  = (bus.dma_len == 16'd0) ? DONE : RUN;
        end
      end
      RUN: begin
        rd_idx_d = rd_idx_q + 16'(dma_rd_go);
        wr_idx_d = wr_idx_q + 16'(dma_wr_go);
        if (wr_idx_q == len_q) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      mode_q   <= 1'b0;
      src_q    <= '0;
      dst_q    <= '0;
      len_q    <= '0;
      fill_q   <= '0;
      rd_idx_q <= '0;
      wr_idx_q <= '0;
      tag_q    <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) buf_q[i] <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      len_q    <= len_d;
      fill_q   <= fill_d;
      rd_idx_q <= rd_idx_d;
      wr_idx_q <= wr_idx_d;
      tag_q    <= tag_d;
      buf_q    <= buf_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  a_no_overflow : assert property (@(posedge clk) disable iff (rst)
    !(push && (cnt_q == CNT_W'(BUF_DEPTH))));

endmodule

// File: tb/tb_mem_dma_arbiter.sv
// Directed bench for mem_dma_arbiter: a memory model, a transfer-level reference
// model (expected DMA write queue) checked every cycle, and literal end-of-test checks.
module tb_mem_dma_arbiter;
  localparam int RD_LAT = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_dma_arbiter_if bus();

  mem_dma_arbiter #(.RD_LAT(RD_LAT), .BUF_DEPTH(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- memory model and reference model state ----------------
  logic [15:0] mem [0:65535];
  logic [15:0] rd_pipe [RD_LAT];
  logic [31:0] exp_q[$];          // {addr, data} of each DMA write still owed
  bit          model_active;
  int          errors, checks, cyc;
  int          stat_wr, stat_first_wr, stat_last_wr, stat_busy, stat_done, stat_done_cyc, stat_ren;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void clear_stats();
    stat_wr = 0; stat_first_wr = -1; stat_last_wr = -1;
    stat_busy = 0; stat_done = 0; stat_done_cyc = -1; stat_ren = 0;
  endfunction

  // Transfer-level model: an accepted start owes exactly len writes, in ascending order.
  function automatic void model_start(bit mode, logic [15:0] src, logic [15:0] dst,
                                      logic [15:0] len, logic [15:0] fill);
    logic [15:0] k;
    if (model_active) return;
    model_active = 1'b1;
    exp_q.delete();
    for (int i = 0; i < int'(len); i++) begin
      k = 16'(i);
      exp_q.push_back({dst + k, mode ? fill : mem[src + k]});
    end
  endfunction

  // ---------------- scoreboard / per-cycle compare ----------------
  task automatic compare();
    logic [31:0] e;
    check("ren_passthru", 32'(bus.mem_ren), 32'(bus.cpu_ren));
    if (bus.mem_ren) stat_ren++;
    if (bus.cpu_ren) check("cpu_raddr", 32'(bus.mem_raddr), 32'(bus.cpu_raddr));
    if (bus.cpu_wen) begin
      check("cpu_wen", 32'(bus.mem_wen), 1);
      check("cpu_waddr", 32'(bus.mem_waddr), 32'(bus.cpu_waddr));
      check("cpu_wdata", 32'(bus.mem_wdata), 32'(bus.cpu_wdata));
    end else if (bus.mem_wen) begin
      stat_wr++;
      if (stat_first_wr < 0) stat_first_wr = cyc;
      stat_last_wr = cyc;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dma_wr_unexpected: got write %h<=%h expected no DMA write (cycle %0d)",
                 bus.mem_waddr, bus.mem_wdata, cyc);
      end else begin
        e = exp_q.pop_front();
        check("dma_waddr", 32'(bus.mem_waddr), 32'(e[31:16]));
        check("dma_wdata", 32'(bus.mem_wdata), 32'(e[15:0]));
      end
    end
    if (bus.dma_busy) stat_busy++;
    if (bus.dma_done) begin
      check("done_when_active", 32'(model_active), 1);
      check("done_queue_empty", exp_q.size(), 0);
      check("busy_in_done", 32'(bus.dma_busy), 0);
      stat_done++;
      stat_done_cyc = cyc;
      model_active = 1'b0;
      exp_q.delete();
    end else if (!model_active) begin
      check("idle_busy", 32'(bus.dma_busy), 0);
    end
  endtask

  // One clock cycle: compare, memory response, then new inputs may be driven.
  task automatic cyc_end();
    @(negedge clk);
    compare();
    for (int i = RD_LAT - 1; i > 0; i--) rd_pipe[i] = rd_pipe[i-1];
    rd_pipe[0] = mem[bus.mem_raddr];
    if (bus.mem_wen) mem[bus.mem_waddr] = bus.mem_wdata;
    @(posedge clk);
    #1;
    bus.mem_rdata = rd_pipe[RD_LAT-1];
    cyc++;
  endtask

  // ---------------- driver tasks ----------------
  task automatic cpu_idle();
    bus.cpu_ren = 1'b0; bus.cpu_raddr = '0;
    bus.cpu_wen = 1'b0; bus.cpu_waddr = '0; bus.cpu_wdata = '0;
  endtask

  task automatic start_dma(bit mode, logic [15:0] src, logic [15:0] dst,
                           logic [15:0] len, logic [15:0] fill);
    bus.dma_mode = mode; bus.dma_src = src; bus.dma_dst = dst;
    bus.dma_len = len; bus.dma_fill = fill; bus.dma_start = 1'b1;
    model_start(mode, src, dst, len, fill);
    cyc_end();
    bus.dma_start = 1'b0;
  endtask

  task automatic wait_done(int budget);
    int n = 0;
    while (stat_done == 0 && n < budget) begin
      cyc_end();
      n++;
    end
    if (stat_done == 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no dma_done within %0d cycles expected a pulse", budget);
    end
    repeat (3) cyc_end();
  endtask

  // ---------------- directed tests ----------------
  int t0;

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = '0;
    for (int i = 0; i < RD_LAT; i++) rd_pipe[i] = '0;
    errors = 0; checks = 0; cyc = 0; model_active = 1'b0;
    clear_stats();
    cpu_idle();
    bus.dma_start = 1'b0; bus.dma_mode = 1'b0; bus.dma_src = '0; bus.dma_dst = '0;
    bus.dma_len = '0; bus.dma_fill = '0; bus.mem_rdata = '0;

    rst = 1'b1;
    #1;
    check("reset_busy", 32'(bus.dma_busy), 0);
    check("reset_done", 32'(bus.dma_done), 0);
    repeat (3) cyc_end();
    rst = 1'b0;
    repeat (2) cyc_end();

    // Fill, idle CPU
    clear_stats();
    t0 = cyc;
    start_dma(1'b1, 16'h0000, 16'hE000, 16'd4, 16'h1234);
    wait_done(50);
    check("fill_first_wr_ofs", stat_first_wr - t0, 1);
    check("fill_wr_span", stat_last_wr - stat_first_wr, 3);
    check("fill_wr_count", stat_wr, 4);
    check("fill_busy_cycles", stat_busy, 5);
    check("fill_done_ofs", stat_done_cyc - t0, 6);
    check("fill_done_pulses", stat_done, 1);
    for (int i = 0; i < 4; i++) check("fill_mem", 32'(mem[16'hE000 + 16'(i)]), 32'h1234);
    check("fill_mem_past_end", 32'(mem[16'hE004]), 0);

    // Copy, idle CPU
    for (int i = 0; i < 8; i++) mem[16'h0100 + 16'(i)] = 16'(i + 1);
    clear_stats();
    t0 = cyc;
    start_dma(1'b0, 16'h0100, 16'hC000, 16'd8, 16'h0000);
    wait_done(80);
    check("copy_first_wr_ofs", stat_first_wr - t0, RD_LAT + 1);
    check("copy_wr_span", stat_last_wr - stat_first_wr, 7);
    check("copy_wr_count", stat_wr, 8);
    check("copy_ren_count", stat_ren, 0);
    check("copy_done_ofs", stat_done_cyc - t0, 12);
    for (int i = 0; i < 8; i++) check("copy_mem", 32'(mem[16'hC000 + 16'(i)]), i + 1);

    // Copy with CPU contention: continuous reads, writes every other cycle
    for (int i = 0; i < 8; i++) mem[16'hC000 + 16'(i)] = '0;
    clear_stats();
    for (int k = 0; k < 10; k++) begin
      bus.cpu_ren   = 1'b1;
      bus.cpu_raddr = 16'h0100 + 16'(k);
      bus.cpu_wen   = (k % 2 == 0);
      bus.cpu_waddr = 16'h3000 + 16'(k);
      bus.cpu_wdata = 16'h7000 + 16'(k);
      if (k == 0) start_dma(1'b0, 16'h0100, 16'hC000, 16'd8, 16'h0000);
      else cyc_end();
    end
    cpu_idle();
    wait_done(80);
    check("cont_wr_count", stat_wr, 8);
    check("cont_done_pulses", stat_done, 1);
    for (int i = 0; i < 8; i++) check("cont_mem", 32'(mem[16'hC000 + 16'(i)]), i + 1);
    for (int k = 0; k < 10; k += 2) check("cont_cpu_mem", 32'(mem[16'h3000 + 16'(k)]), 32'h7000 + k);
    check("cont_cpu_mem_odd", 32'(mem[16'h3001]), 0);

    // Address wrap; DMA reads never raise ren
    mem[16'hFFFE] = 16'hAAAA; mem[16'hFFFF] = 16'hBBBB; mem[16'h0000] = 16'hCCCC;
    clear_stats();
    start_dma(1'b0, 16'hFFFE, 16'h0200, 16'd3, 16'h0000);
    wait_done(50);
    check("wrap_mem0", 32'(mem[16'h0200]), 32'hAAAA);
    check("wrap_mem1", 32'(mem[16'h0201]), 32'hBBBB);
    check("wrap_mem2", 32'(mem[16'h0202]), 32'hCCCC);
    check("wrap_ren_count", stat_ren, 0);

    // Zero length
    clear_stats();
    t0 = cyc;
    start_dma(1'b1, 16'h0000, 16'h4000, 16'd0, 16'hFFFF);
    wait_done(20);
    check("len0_done_ofs", stat_done_cyc - t0, 1);
    check("len0_wr_count", stat_wr, 0);
    check("len0_busy_cycles", stat_busy, 0);
    check("len0_done_pulses", stat_done, 1);

    // Start while running is ignored
    clear_stats();
    start_dma(1'b1, 16'h0000, 16'hD000, 16'd6, 16'h5555);
    cyc_end();
    start_dma(1'b1, 16'h0000, 16'hD100, 16'd2, 16'h9999);
    wait_done(50);
    check("busy_start_wr_count", stat_wr, 6);
    check("busy_start_done_pulses", stat_done, 1);
    check("busy_start_last", 32'(mem[16'hD005]), 32'h5555);
    check("busy_start_past_end", 32'(mem[16'hD006]), 0);
    check("busy_start_ignored", 32'(mem[16'hD100]), 0);

    // Reset mid-copy
    clear_stats();
    start_dma(1'b0, 16'h0100, 16'hC200, 16'd8, 16'h0000);
    repeat (5) cyc_end();
    check("midrst_pre_wr_count", stat_wr, 3);
    rst = 1'b1;
    #1;
    check("midrst_busy_async", 32'(bus.dma_busy), 0);
    model_active = 1'b0;
    exp_q.delete();
    clear_stats();
    repeat (2) cyc_end();
    rst = 1'b0;
    repeat (20) cyc_end();
    check("midrst_no_writes", stat_wr, 0);
    check("midrst_no_done", stat_done, 0);
    check("midrst_no_busy", stat_busy, 0);
    check("midrst_mem_written", 32'(mem[16'hC202]), 3);
    check("midrst_mem_untouched", 32'(mem[16'hC203]), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
